// File: rtl/uart_pkg.sv
// UART shared definitions: default frame parameters and FSM state encoding.
package uart_pkg;

    localparam int DBIT_DEF        = 8;
    localparam int SB_TICK_DEF     = 16;
    localparam int FIFO_ADDR_W_DEF = 2;
    localparam int TFV_W           = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO, first-word-fall-through read, registered full/empty flags.
module uart_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] w_data,
    output logic [W-1:0] r_data,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wp, rp, wp_n, rp_n;
    logic          do_wr, do_rd;

    // A read frees a slot, so a write alongside it is accepted even when full
    assign do_rd  = rd && !empty;
    assign do_wr  = wr && (!full || do_rd);
    assign wp_n   = wp + 1'b1;
    assign rp_n   = rp + 1'b1;
    assign r_data = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_wr) begin
                mem[wp] <= w_data;
                wp      <= wp_n;
            end
            if (do_rd) rp <= rp_n;
            case ({do_wr, do_rd})
                2'b10: begin
                    empty <= 1'b0;
                    full  <= (wp_n == rp);
                end
                2'b01: begin
                    full  <= 1'b0;
                    empty <= (rp_n == wp);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart.sv
// UART with 16x oversampling baud generator, TX/RX FSMs and TX/RX FIFOs.
module uart
    import uart_pkg::*;
#(
    parameter int DBIT        = DBIT_DEF,
    parameter int SB_TICK     = SB_TICK_DEF,
    parameter int FIFO_ADDR_W = FIFO_ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DBIT-1:0]  w_data,
    input  logic             wr_uart,
    output logic             tx_full,
    output logic             tx,
    input  logic             rx,
    input  logic             rd_uart,
    output logic             rx_empty,
    output logic [DBIT-1:0]  r_data,
    input  logic [TFV_W-1:0] timer_final_value
);
    localparam int            NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic [4:0]    S_LAST = 5'(SB_TICK - 1);

    logic [TFV_W-1:0] b_cnt, b_lim;
    logic             tick;

    state_t          ts, rs;
    logic [4:0]      ts_cnt, rs_cnt;
    logic [NW-1:0]   tn, rn;
    logic [DBIT-1:0] tb, rb, tx_head;
    logic            tx_done, tx_empty;
    logic            rx_done, rx_full;
    logic [1:0]      rx_sync;
    logic            rx_s;

    // Divisor is sampled at the wrap so a new value never truncates a period
    assign tick = (b_cnt == b_lim);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            b_cnt <= '0;
            b_lim <= '0;
        end else if (tick) begin
            b_cnt <= '0;
            b_lim <= timer_final_value;
        end else begin
            b_cnt <= b_cnt + 1'b1;
        end
    end

    uart_fifo #(.W(DBIT), .AW(FIFO_ADDR_W)) u_tx_fifo (
        .clk    (clk),
        .rst    (reset_n),
        .wr     (wr_uart),
        .rd     (tx_done),
        .w_data (w_data),
        .r_data (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    // tx_done blocks IDLE for one cycle while the popped head retires
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            ts      <= IDLE;
            ts_cnt  <= '0;
            tn      <= '0;
            tb      <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (ts)
                IDLE: if (!tx_empty && !tx_done) begin
                    tb     <= tx_head;
                    ts_cnt <= '0;
                    tx     <= 1'b0;
                    ts     <= START;
                end
                START: if (tick) begin
                    if (ts_cnt == 5'd15) begin
                        ts_cnt <= '0;
                        tn     <= '0;
                        tx     <= tb[0];
                        ts     <= DATA;
                    end else begin
                        ts_cnt <= ts_cnt + 1'b1;
                    end
                end
                DATA: if (tick) begin
                    if (ts_cnt == 5'd15) begin
                        ts_cnt <= '0;
                        tb     <= tb >> 1;
                        if (tn == N_LAST) begin
                            tx <= 1'b1;
                            ts <= STOP;
                        end else begin
                            tn <= tn + 1'b1;
                            tx <= tb[1];
                        end
                    end else begin
                        ts_cnt <= ts_cnt + 1'b1;
                    end
                end
                STOP: if (tick) begin
                    if (ts_cnt == S_LAST) begin
                        tx_done <= 1'b1;
                        ts      <= IDLE;
                    end else begin
                        ts_cnt <= ts_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            rx_sync <= 2'b11;
            rs      <= IDLE;
            rs_cnt  <= '0;
            rn      <= '0;
            rb      <= '0;
            rx_done <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_done <= 1'b0;
            unique case (rs)
                IDLE: if (!rx_s) begin
                    rs_cnt <= '0;
                    rs     <= START;
                end
                START: if (tick) begin
                    if (rs_cnt == 5'd7) begin
                        rs_cnt <= '0;
                        rn     <= '0;
                        rs     <= rx_s ? IDLE : DATA;
                    end else begin
                        rs_cnt <= rs_cnt + 1'b1;
                    end
                end
                DATA: if (tick) begin
                    if (rs_cnt == 5'd15) begin
                        rs_cnt <= '0;
                        rb     <= {rx_s, rb[DBIT-1:1]};
                        if (rn == N_LAST) rs <= STOP;
                        else              rn <= rn + 1'b1;
                    end else begin
                        rs_cnt <= rs_cnt + 1'b1;
                    end
                end
                STOP: if (tick) begin
                    if (rs_cnt == S_LAST) begin
                        rx_done <= 1'b1;
                        rs      <= IDLE;
                    end else begin
                        rs_cnt <= rs_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    uart_fifo #(.W(DBIT), .AW(FIFO_ADDR_W)) u_rx_fifo (
        .clk    (clk),
        .rst    (reset_n),
        .wr     (rx_done && !rx_full),
        .rd     (rd_uart),
        .w_data (rb),
        .r_data (r_data),
        .full   (rx_full),
        .empty  (rx_empty)
    );

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: timing tables, loopback scoreboard, corner cases.
module tb_uart;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_uart = 1'b0;
    logic        rd_uart = 1'b0;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic [7:0]  w_data = 8'h00;
    logic [10:0] tfv = 11'd53;
    logic        tx, tx_full, rx_empty, rx;
    logic [7:0]  r_data;

    int total = 0;
    int passed = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       full_after;
    } vec_t;
    vec_t vecs[6];
    logic [7:0] burst[4];

    assign rx = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    uart dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .w_data            (w_data),
        .wr_uart           (wr_uart),
        .tx_full           (tx_full),
        .tx                (tx),
        .rx                (rx),
        .rd_uart           (rd_uart),
        .rx_empty          (rx_empty),
        .r_data            (r_data),
        .timer_final_value (tfv)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, req);
    endtask

    task automatic timeout(input string nm);
        total++;
        $display("FAIL %s: got timeout, want event", nm);
    endtask

    task automatic wait_tx(input logic v, input int maxc,
                           input string nm, output int n);
        n = 0;
        while (tx !== v && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (tx !== v) timeout(nm);
    endtask

    task automatic push_wr(input logic [7:0] d);
        wr_uart = 1'b1;
        w_data  = d;
        exp_q.push_back(d);
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic pop_rx(input string nm);
        int n = 0;
        logic [7:0] e;
        while (rx_empty && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (rx_empty) begin
            timeout(nm);
            return;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk(nm, r_data, e);
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
    endtask

    task automatic decode(input int bit_clks, input string nm);
        int n;
        logic [7:0] d;
        logic [7:0] e;
        wait_tx(1'b0, 2000, nm, n);
        if (tx !== 1'b0) return;
        repeat (bit_clks / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (bit_clks) @(negedge clk);
            d[i] = tx;
        end
        repeat (bit_clks) @(negedge clk);
        chk({nm, "_stop"}, tx, 1'b1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk(nm, d, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int lows;

        vecs = '{'{8'h11, 1'b0}, '{8'h22, 1'b0}, '{8'h33, 1'b0},
                 '{8'h44, 1'b1}, '{8'h55, 1'b1}, '{8'h66, 1'b1}};
        burst = '{8'h55, 8'hA3, 8'h00, 8'hFF};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_tx_full", tx_full, 1'b0);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_r_data", r_data, 8'h00);
        reset_n = 1'b0;

        // Loopback 0x7E at divisor 53: 864 clocks per bit
        loop = 1'b1;
        tfv  = 11'd53;
        repeat (2) @(negedge clk);
        push_wr(8'h7E);
        wait_tx(1'b0, 3000, "t2_start", n);
        wait_tx(1'b1, 5000, "t2_low0", n);
        wait_tx(1'b0, 8000, "t2_high", n);
        chk("t2_bits1to6_clks", n, 5184);
        wait_tx(1'b1, 2000, "t2_bit7", n);
        chk("t2_bit7_clks", n, 864);
        chk("t2_empty_before_stop", rx_empty, 1'b1);
        pop_rx("t2_rx_7e");
        chk("t2_empty_after_rd", rx_empty, 1'b1);

        // Back-to-back burst, read only after all four frames land
        tfv = 11'd3;
        repeat (100) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wr_uart = 1'b1;
            w_data  = burst[i];
            exp_q.push_back(burst[i]);
            @(negedge clk);
        end
        wr_uart = 1'b0;
        chk("t3_tx_full", tx_full, 1'b1);
        repeat (3200) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t3_not_empty", rx_empty, 1'b0);
            pop_rx("t3_rx_burst");
        end
        chk("t3_empty_after_4", rx_empty, 1'b1);

        // Six-cycle write hold, no loopback: only four frames leave
        loop   = 1'b0;
        rx_drv = 1'b1;
        tfv    = 11'd0;
        repeat (100) @(negedge clk);
        fork
            begin
                cnt = 0;
                for (int i = 0; i < 6; i++) begin
                    wr_uart = 1'b1;
                    w_data  = vecs[i].data;
                    if (cnt < 4) begin
                        exp_q.push_back(vecs[i].data);
                        cnt++;
                    end
                    @(negedge clk);
                    chk("t4_tx_full", tx_full, vecs[i].full_after);
                end
                wr_uart = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) decode(16, "t4_frame");
            end
        join
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("t4_no_extra_frame", lows, 0);
        chk("t4_tx_full_end", tx_full, 1'b0);

        // Short rx glitch is a false start
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        chk("t5_glitch_empty", rx_empty, 1'b1);

        // Divisor 0: 16-clock bits, 0x3C loopback
        loop = 1'b1;
        repeat (5) @(negedge clk);
        push_wr(8'h3C);
        wait_tx(1'b0, 200, "t6_start", n);
        wait_tx(1'b1, 200, "t6_low", n);
        chk("t6_low_run", n, 48);
        wait_tx(1'b0, 200, "t6_high", n);
        chk("t6_high_run", n, 64);
        pop_rx("t6_rx_3c");

        // Reset in the middle of the data bits
        tfv = 11'd3;
        repeat (20) @(negedge clk);
        wr_uart = 1'b1;
        w_data  = 8'hA5;
        @(negedge clk);
        wr_uart = 1'b0;
        wait_tx(1'b0, 300, "t7_start", n);
        repeat (192) @(negedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("t7_tx_async", tx, 1'b1);
        chk("t7_tx_full", tx_full, 1'b0);
        chk("t7_rx_empty", rx_empty, 1'b1);
        chk("t7_r_data", r_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (1500) @(negedge clk);
        chk("t7_no_partial", rx_empty, 1'b1);
        chk("t7_tx_idle", tx, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
